// File: rtl/flow_table_responder_if.sv
// rtl/flow_table_responder_if.sv - lookup request / response bundle for flow_table_responder
interface flow_table_responder_if #(
    parameter int C_KEY_WIDTH  = 96,
    parameter int C_INDEX_BITS = 10,
    parameter int C_ID_WIDTH   = 23
) ();
    logic                    in_valid_key;
    logic [C_KEY_WIDTH-1:0]  in_key;
    logic                    in_flush;
    logic                    out_valid_id;
    logic [C_ID_WIDTH-1:0]   out_id;
    logic                    out_new;
    logic [C_INDEX_BITS:0]   out_occupancy;

    modport master (
        output in_valid_key, in_key, in_flush,
        input  out_valid_id, out_id, out_new, out_occupancy
    );

    modport slave (
        input  in_valid_key, in_key, in_flush,
        output out_valid_id, out_id, out_new, out_occupancy
    );
endinterface

// File: rtl/flow_table_responder.sv
// rtl/flow_table_responder.sv - direct-mapped flow table with insert-on-miss lookups
module flow_table_responder #(
    parameter int C_KEY_WIDTH  = 96,
    parameter int C_INDEX_BITS = 10,
    parameter int C_ID_WIDTH   = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    flow_table_responder_if.slave bus
);
    localparam int DEPTH  = 1 << C_INDEX_BITS;
    localparam int NSLICE = (C_KEY_WIDTH + C_INDEX_BITS - 1) / C_INDEX_BITS;
    localparam int PADW   = NSLICE * C_INDEX_BITS;
    localparam logic [C_INDEX_BITS:0] OCC_ONE = (C_INDEX_BITS+1)'(1);

    typedef logic [C_INDEX_BITS-1:0] idx_t;
    typedef logic [C_KEY_WIDTH-1:0]  key_t;

    function automatic idx_t fold_key(input key_t key);
        logic [PADW-1:0] padded;
        idx_t            r;
        padded = PADW'(key);
        r      = '0;
        for (int s = 0; s < NSLICE; s++) begin
            r = r ^ padded[s*C_INDEX_BITS +: C_INDEX_BITS];
        end
        return r;
    endfunction

    // Stage 1: key captured and folded; stage 2: RAM data returns; evaluation at the next edge.
    logic                  s1_valid_q, s1_valid_d;
    key_t                  s1_key_q,   s1_key_d;
    idx_t                  s1_idx_q,   s1_idx_d;
    logic                  s2_valid_q, s2_valid_d;
    key_t                  s2_key_q,   s2_key_d;
    idx_t                  s2_idx_q,   s2_idx_d;
    logic                  byp_valid_q, byp_valid_d;
    key_t                  byp_key_q,   byp_key_d;
    logic [DEPTH-1:0]      valid_q,    valid_d;
    logic [C_INDEX_BITS:0] occ_q,      occ_d;
    logic                  out_valid_q, out_valid_d;
    logic [C_ID_WIDTH-1:0] out_id_q,    out_id_d;
    logic                  out_new_q,   out_new_d;

    key_t key_ram [DEPTH];
    key_t ram_rdata;

    logic entry_valid;
    key_t stored_key;
    logic is_hit;
    logic is_empty;
    logic wr_en;

    // The RAM read issued alongside an insert returns old data; the bypass register covers that one edge.
    always_comb begin
        entry_valid = valid_q[s2_idx_q];
        stored_key  = byp_valid_q ? byp_key_q : ram_rdata;
        is_hit      = entry_valid && (stored_key == s2_key_q);
        is_empty    = !entry_valid;
        wr_en       = s2_valid_q && is_empty && !bus.in_flush;
    end

    always_comb begin
        s1_valid_d  = bus.in_valid_key;
        s1_key_d    = bus.in_key;
        s1_idx_d    = fold_key(bus.in_key);
        s2_valid_d  = s1_valid_q;
        s2_key_d    = s1_key_q;
        s2_idx_d    = s1_idx_q;
        byp_valid_d = wr_en && (s2_idx_q == s1_idx_q);
        byp_key_d   = s2_key_q;
        valid_d     = valid_q;
        occ_d       = occ_q;
        out_valid_d = s2_valid_q;
        out_new_d   = s2_valid_q && is_empty;
        out_id_d    = '0;

        if (wr_en) begin
            valid_d[s2_idx_q] = 1'b1;
            occ_d             = occ_q + OCC_ONE;
        end
        // Flush wins over an insert evaluated on the same edge.
        if (bus.in_flush) begin
            valid_d = '0;
            occ_d   = '0;
        end
        if (s2_valid_q) begin
            out_id_d[C_INDEX_BITS-1:0] = s2_idx_q;
            out_id_d[C_ID_WIDTH-1]     = !is_hit && !is_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_key_q    <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_key_q    <= '0;
            s2_idx_q    <= '0;
            byp_valid_q <= 1'b0;
            byp_key_q   <= '0;
            valid_q     <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_new_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_key_q    <= s1_key_d;
            s1_idx_q    <= s1_idx_d;
            s2_valid_q  <= s2_valid_d;
            s2_key_q    <= s2_key_d;
            s2_idx_q    <= s2_idx_d;
            byp_valid_q <= byp_valid_d;
            byp_key_q   <= byp_key_d;
            valid_q     <= valid_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_new_q   <= out_new_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_ram[s2_idx_q] <= s2_key_q;
        end
        ram_rdata <= key_ram[s1_idx_q];
    end

    assign bus.out_valid_id  = out_valid_q;
    assign bus.out_id        = out_id_q;
    assign bus.out_new       = out_new_q;
    assign bus.out_occupancy = occ_q;
endmodule

// File: tb/tb_flow_table_responder.sv
// tb/tb_flow_table_responder.sv - randomized bench with behavioural flow table model
module tb_flow_table_responder;
    localparam int KW    = 96;
    localparam int IB    = 10;
    localparam int IW    = 23;
    localparam int DEPTH = 1 << IB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    flow_table_responder_if #(.C_KEY_WIDTH(KW), .C_INDEX_BITS(IB), .C_ID_WIDTH(IW)) ftr_if ();

    flow_table_responder #(.C_KEY_WIDTH(KW), .C_INDEX_BITS(IB), .C_ID_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ftr_if)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IB-1:0] model_fold(input logic [KW-1:0] k);
        logic [IB-1:0] idx = '0;
        for (int sh = 0; sh < KW; sh += IB) begin
            idx = idx ^ IB'((k >> sh) & 96'h3FF);
        end
        return idx;
    endfunction

    typedef struct {
        logic [KW-1:0] key;
        int            e;
    } pend_t;

    bit              m_valid [DEPTH];
    logic [KW-1:0]   m_key   [DEPTH];
    pend_t           pend[$];
    int              cyc = 0;
    bit              started = 0;
    logic            exp_v = 0;
    logic [IW-1:0]   exp_id = '0;
    logic            exp_new = 0;
    int              exp_occ = 0;

    // Model: each request resolves two edges after sampling, in order, against the table as it stands.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                foreach (m_valid[i]) m_valid[i] = 0;
                pend.delete();
                exp_v = 0; exp_id = '0; exp_new = 0; exp_occ = 0;
                started = 1;
            end else begin
                exp_v = 0; exp_id = '0; exp_new = 0;
                if (pend.size() > 0 && pend[0].e == cyc - 2) begin
                    pend_t         p;
                    logic [IB-1:0] idx;
                    p   = pend.pop_front();
                    idx = model_fold(p.key);
                    exp_v = 1;
                    exp_id[IB-1:0] = idx;
                    if (!m_valid[idx]) begin
                        exp_new = 1;
                        if (!ftr_if.in_flush) begin
                            m_valid[idx] = 1;
                            m_key[idx]   = p.key;
                        end
                    end else if (m_key[idx] != p.key) begin
                        exp_id[IW-1] = 1'b1;
                    end
                end
                if (ftr_if.in_flush) foreach (m_valid[i]) m_valid[i] = 0;
                if (ftr_if.in_valid_key) pend.push_back('{key: ftr_if.in_key, e: cyc});
                exp_occ = 0;
                foreach (m_valid[i]) exp_occ += int'(m_valid[i]);
            end
        end
    end

    typedef struct {
        logic [IW-1:0] id;
        logic          nw;
    } resp_t;
    resp_t resp_q[$];
    bit    log_en = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("out_valid_id", 128'(ftr_if.out_valid_id), 128'(exp_v));
                check("out_id", 128'(ftr_if.out_id), 128'(exp_id));
                check("out_new", 128'(ftr_if.out_new), 128'(exp_new));
                check("out_occupancy", 128'(ftr_if.out_occupancy), 128'(exp_occ));
            end
            if (log_en && ftr_if.out_valid_id) resp_q.push_back('{id: ftr_if.out_id, nw: ftr_if.out_new});
        end
    end

    task automatic drive(input logic v, input logic [KW-1:0] k, input logic f);
        @(negedge clk);
        ftr_if.in_valid_key = v;
        ftr_if.in_key       = k;
        ftr_if.in_flush     = f;
    endtask

    task automatic send(input logic [KW-1:0] k);
        drive(1'b1, k, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    task automatic expect_resp(input string name, input logic [IW-1:0] id, input logic nw);
        resp_t r;
        tests++;
        if (resp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: no response, expected id 0x%0h new %0d", name, id, nw);
        end else begin
            r = resp_q.pop_front();
            if (r.id !== id || r.nw !== nw) begin
                fails++;
                $display("FAIL %s: got id 0x%0h new %0d expected id 0x%0h new %0d", name, r.id, r.nw, id, nw);
            end
        end
    endtask

    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] k;
        int            sh;
        if ($urandom_range(0, 3) == 0) begin
            k = {$urandom(), $urandom(), $urandom()};
        end else begin
            sh = IB * int'($urandom_range(0, 9));
            k  = KW'($urandom_range(0, 7)) << sh;
        end
        return k;
    endfunction

    initial begin
        ftr_if.in_valid_key = 1'b0;
        ftr_if.in_key       = '0;
        ftr_if.in_flush     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        log_en = 1;
        check("reset_valid", 128'(ftr_if.out_valid_id), 128'd0);
        check("reset_occ", 128'(ftr_if.out_occupancy), 128'd0);

        send(96'h1); idle(4); send(96'h1); idle(4);
        expect_resp("insert_first", 23'h000001, 1'b1);
        expect_resp("insert_hit", 23'h000001, 1'b0);
        check("insert_occ", 128'(ftr_if.out_occupancy), 128'd1);

        send(96'h400); idle(4);
        expect_resp("collision", 23'h400001, 1'b0);
        check("collision_occ", 128'(ftr_if.out_occupancy), 128'd1);

        send(96'h2); send(96'h2); send(96'h2); idle(4);
        expect_resp("b2b_0", 23'h000002, 1'b1);
        expect_resp("b2b_1", 23'h000002, 1'b0);
        expect_resp("b2b_2", 23'h000002, 1'b0);
        check("b2b_occ", 128'(ftr_if.out_occupancy), 128'd2);

        send(96'h401); idle(4);
        expect_resp("fold", 23'h000000, 1'b1);

        send(96'h1); drive(1'b0, '0, 1'b0); drive(1'b0, '0, 1'b1); idle(4);
        expect_resp("flush_hit", 23'h000001, 1'b0);
        check("flush_occ", 128'(ftr_if.out_occupancy), 128'd0);
        send(96'h1); idle(4);
        expect_resp("after_flush", 23'h000001, 1'b1);

        send(96'h5);
        drive(1'b1, 96'h6, 1'b0); reset = 1'b1;
        drive(1'b0, '0, 1'b0); reset = 1'b0;
        idle(5);
        check("reset_no_resp", 128'(resp_q.size()), 128'd0);
        check("reset_mid_occ", 128'(ftr_if.out_occupancy), 128'd0);
        send(96'h1); idle(4);
        expect_resp("after_reset", 23'h000001, 1'b1);
        log_en = 0;

        for (int c = 0; c < 2500; c++) begin
            drive(($urandom_range(0, 9) < 7), rand_key(), ($urandom_range(0, 59) == 0));
            reset = ($urandom_range(0, 299) == 0);
        end
        drive(1'b0, '0, 1'b0); reset = 1'b1;
        drive(1'b0, '0, 1'b0); reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) send(KW'(i));
        idle(4);
        check("full_occ", 128'(ftr_if.out_occupancy), 128'(DEPTH));
        for (int c = 0; c < 400; c++) drive(($urandom_range(0, 3) != 0), rand_key(), 1'b0);
        idle(4);
        check("full_occ_after", 128'(ftr_if.out_occupancy), 128'(DEPTH));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
